lbus_resp: RTL and testbench
============================

# lbus_resp

Memory-side responder for the 1024-bit cache-line bus driven by the data cache. Serves line-fill reads by fetching sixteen 64-bit beats from a narrow word-addressed memory port and presenting the assembled line with a one-cycle data-valid pulse. Absorbs single-cycle write-through pulses into a one-entry write buffer and drains them as sixteen beat writes. Sits between the L1 data cache and the system memory controller.

## Interface
- LINE_W, 1024, line width in bits (fixed: 16 × BEAT_W)
- BEAT_W, 64, memory-port beat width
- ADDR_W, 64, address width
- clk  in  1  clock, all state on rising edge
- clr  in  1  reset, asynchronous, active-high
- l_addr  in  ADDR_W  line address from cache; bits [6:0] ignored
- l_rd  in  1  line-fill request, level, held until l_dv
- l_dv  out  1  line data valid, one-cycle pulse
- l_rdata  out  LINE_W  assembled line, registered
- l_wr  in  1  write-through pulse, one cycle
- l_wdata  in  LINE_W  full line to write, valid with l_wr
- ovf  out  1  sticky write-overrun flag
- m_addr  out  ADDR_W  beat address, 8-byte aligned
- m_rd  out  1  beat read request
- m_wr  out  1  beat write request
- m_wdata  out  BEAT_W  beat write data
- m_rdata  in  BEAT_W  beat read data, valid with m_ack
- m_ack  in  1  memory beat acknowledge

## Operation
- States: IDLE, RD, RD_DONE, WR.
- Write buffer: one entry {line addr [63:7], LINE_W data, full bit}. l_wr with buffer empty: capture l_addr[63:7], l_wdata, set full. Accepted in any state, including same cycle as drain completion clearing full (new write wins, full stays 1).
- l_wr while full and not clearing that cycle: write dropped, ovf set; ovf clears only on clr.
- IDLE: full → WR (priority over read, preserves write-then-read ordering); else l_rd → latch l_addr[63:7], beat counter 0, → RD.
- RD: m_rd=1, m_addr={line, cnt[3:0], 3'b000}. On m_ack: l_rdata[64*cnt +: 64] ← m_rdata, cnt+1; on ack of beat 15 → RD_DONE.
- RD_DONE: l_dv=1 for this cycle, → IDLE. l_rd deasserting mid-read does not abort; read completes and pulses l_dv.
- WR: m_wr=1, m_addr from buffer, m_wdata=buffer[64*cnt +: 64]. On m_ack cnt+1; on ack of beat 15 clear full, → IDLE.
- Beats strictly ascending, 0..15; counter wraps 15→0 only on state exit.
- Never m_rd and m_wr together.

## Timing
- Reset values: l_dv=0, l_rdata=0, ovf=0, m_rd=0, m_wr=0, m_addr=0, m_wdata=0; state IDLE, cnt 0, buffer empty.
- m_rd/m_wr, m_addr, m_wdata registered; held stable until m_ack sampled high. Next beat request presented the cycle after the ack (back-to-back with no idle cycle when m_ack is held high).
- Read latency with zero-wait memory: l_rd sampled in IDLE at cycle 0 → first m_rd at cycle 1 → l_dv at cycle 18.
- l_rdata changes only on beat capture; stable from l_dv until the next read's first ack.
- IDLE lasts ≥1 cycle after RD_DONE, so the cache's dropped l_rd is seen before a re-issue.
- clr mid-transaction: outputs return to reset values immediately; partial line and buffered write discarded.

## Structure
- Package lbus_pkg: LINE_W, BEAT_W, BEATS=16, beat-index width 4, state encoding for IDLE/RD/RD_DONE/WR.
- Sub-module lbus_wbuf: one-entry write buffer (capture, full, clear, overrun detect, ovf). FSM, beat counter and read assembly stay in lbus_resp.

## Test plan
- Zero-wait read: mem word at byte addr A holds A; l_rd with l_addr=0x1000 → m_rd at 0x1000..0x1078 step 8, l_dv at cycle 18, l_rdata[64*i +: 64]=0x1000+8i.
- Wait states: m_ack after 3 cycles per beat, read at 0x2080 → m_addr/m_rd held through waits, exactly 16 acks consumed, single l_dv pulse.
- Write drain: l_wr with l_addr=0x3000, l_wdata beat i = 0xA5A5_0000+i → 16 m_wr beats, m_wdata matches, buffer empty after beat 15 ack.
- Ordering: l_wr and l_rd to 0x4000 together in IDLE → all 16 m_wr complete before first m_rd; returned line equals written data.
- Overrun: l_wr to 0x5000, then l_wr to 0x6000 during its drain (m_ack delayed) → second write dropped, ovf=1 until clr, only 0x5000 beats written.
- clr asserted at beat 7 of a read → m_rd=0, l_dv=0 next edge; subsequent read at 0x7000 completes normally.

Source files
------------

// File: rtl/lbus_pkg.sv
// Shared widths, state encoding and address helper for the cache-line bus responder.
package lbus_pkg;

  localparam int unsigned LINE_W  = 1024;
  localparam int unsigned BEAT_W  = 64;
  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned BEATS   = 16;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned OFF_W   = 7;
  localparam int unsigned LADDR_W = ADDR_W - OFF_W;

  typedef enum logic [1:0] {
    StIdle,
    StRd,
    StRdDone,
    StWr
  } state_e;

  // Byte address of beat idx within a line.
  function automatic logic [ADDR_W-1:0] beat_addr(input logic [LADDR_W-1:0] line,
                                                  input logic [CNT_W-1:0]   idx);
    return {line, idx, 3'b000};
  endfunction

endpackage

// File: rtl/lbus_wbuf.sv
// One-entry write-through buffer: captures a full line, holds it until drained,
// and flags any write that arrives while it is occupied.
module lbus_wbuf
  import lbus_pkg::*;
(
  input  logic               clk,
  input  logic               clr,
  input  logic               i_wr,
  input  logic               i_clear,
  input  logic [LADDR_W-1:0] i_line,
  input  logic [LINE_W-1:0]  i_data,
  output logic               o_full,
  output logic               o_ovf,
  output logic [LADDR_W-1:0] o_line,
  output logic [LINE_W-1:0]  o_data
);

  logic               r_full;
  logic               r_ovf;
  logic [LADDR_W-1:0] r_line;
  logic [LINE_W-1:0]  r_data;
  logic               w_accept;
  logic               w_drop;

  // A write landing on the drain-completion cycle takes the freed slot.
  assign w_accept = i_wr && (!r_full || i_clear);
  assign w_drop   = i_wr && r_full && !i_clear;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_full <= 1'b0;
      r_ovf  <= 1'b0;
      r_line <= '0;
      r_data <= '0;
    end else begin
      if (w_accept) begin
        r_full <= 1'b1;
        r_line <= i_line;
        r_data <= i_data;
      end else if (i_clear) begin
        r_full <= 1'b0;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign o_full = r_full;
  assign o_ovf  = r_ovf;
  assign o_line = r_line;
  assign o_data = r_data;

endmodule

// File: rtl/lbus_resp.sv
// Line-fill / write-through responder: splits 1024-bit line transfers into sixteen
// ascending 64-bit beats on the memory port, draining buffered writes before reads.
module lbus_resp
  import lbus_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic              l_rd,
  output logic              l_dv,
  output logic [LINE_W-1:0] l_rdata,
  input  logic              l_wr,
  input  logic [LINE_W-1:0] l_wdata,
  output logic              ovf,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_rd,
  output logic              m_wr,
  output logic [BEAT_W-1:0] m_wdata,
  input  logic [BEAT_W-1:0] m_rdata,
  input  logic              m_ack
);

  state_e             r_state, w_state_d;
  logic [CNT_W-1:0]   r_cnt, w_cnt_d, w_cnt_inc;
  logic [LADDR_W-1:0] r_rd_line, w_rd_line_d;
  logic               r_m_rd, w_m_rd_d;
  logic               r_m_wr, w_m_wr_d;
  logic [ADDR_W-1:0]  r_m_addr, w_m_addr_d;
  logic [BEAT_W-1:0]  r_m_wdata, w_m_wdata_d;
  logic               r_l_dv, w_l_dv_d;
  logic [LINE_W-1:0]  r_l_rdata;

  logic               w_full;
  logic               w_clear;
  logic               w_capture;
  logic               w_last;
  logic [LADDR_W-1:0] w_buf_line;
  logic [LINE_W-1:0]  w_buf_data;
  logic [LADDR_W-1:0] w_src_line;
  logic [LINE_W-1:0]  w_src_data;
  logic               w_unused;

  assign w_unused  = ^l_addr[OFF_W-1:0];
  assign w_last    = (r_cnt == CNT_W'(BEATS - 1));
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // A write arriving in IDLE is drained straight away, so its first beat is taken
  // from the bus while the buffer captures it on the same edge.
  assign w_src_line = w_full ? w_buf_line : l_addr[ADDR_W-1:OFF_W];
  assign w_src_data = w_full ? w_buf_data : l_wdata;

  lbus_wbuf u_wbuf (
    .clk     (clk),
    .clr     (clr),
    .i_wr    (l_wr),
    .i_clear (w_clear),
    .i_line  (l_addr[ADDR_W-1:OFF_W]),
    .i_data  (l_wdata),
    .o_full  (w_full),
    .o_ovf   (ovf),
    .o_line  (w_buf_line),
    .o_data  (w_buf_data)
  );

  always_comb begin
    w_state_d   = r_state;
    w_cnt_d     = r_cnt;
    w_rd_line_d = r_rd_line;
    w_m_rd_d    = r_m_rd;
    w_m_wr_d    = r_m_wr;
    w_m_addr_d  = r_m_addr;
    w_m_wdata_d = r_m_wdata;
    w_l_dv_d    = 1'b0;
    w_capture   = 1'b0;
    w_clear     = 1'b0;

    case (r_state)
      StIdle: begin
        if (w_full || l_wr) begin
          w_state_d   = StWr;
          w_cnt_d     = '0;
          w_m_wr_d    = 1'b1;
          w_m_addr_d  = beat_addr(w_src_line, '0);
          w_m_wdata_d = w_src_data[BEAT_W-1:0];
        end else if (l_rd && !r_l_dv) begin
          // Skipping the l_dv cycle lets the cache drop l_rd before a re-issue.
          w_state_d   = StRd;
          w_cnt_d     = '0;
          w_rd_line_d = l_addr[ADDR_W-1:OFF_W];
          w_m_rd_d    = 1'b1;
          w_m_addr_d  = beat_addr(l_addr[ADDR_W-1:OFF_W], '0);
        end
      end

      StRd: begin
        if (m_ack) begin
          w_capture = 1'b1;
          if (w_last) begin
            w_state_d = StRdDone;
            w_cnt_d   = '0;
            w_m_rd_d  = 1'b0;
          end else begin
            w_cnt_d    = w_cnt_inc;
            w_m_addr_d = beat_addr(r_rd_line, w_cnt_inc);
          end
        end
      end

      StRdDone: begin
        w_l_dv_d  = 1'b1;
        w_state_d = StIdle;
      end

      StWr: begin
        if (m_ack) begin
          if (w_last) begin
            w_clear   = 1'b1;
            w_state_d = StIdle;
            w_cnt_d   = '0;
            w_m_wr_d  = 1'b0;
          end else begin
            w_cnt_d     = w_cnt_inc;
            w_m_addr_d  = beat_addr(w_buf_line, w_cnt_inc);
            w_m_wdata_d = w_buf_data[BEAT_W*w_cnt_inc +: BEAT_W];
          end
        end
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_rd_line <= '0;
      r_m_rd    <= 1'b0;
      r_m_wr    <= 1'b0;
      r_m_addr  <= '0;
      r_m_wdata <= '0;
      r_l_dv    <= 1'b0;
      r_l_rdata <= '0;
    end else begin
      r_state   <= w_state_d;
      r_cnt     <= w_cnt_d;
      r_rd_line <= w_rd_line_d;
      r_m_rd    <= w_m_rd_d;
      r_m_wr    <= w_m_wr_d;
      r_m_addr  <= w_m_addr_d;
      r_m_wdata <= w_m_wdata_d;
      r_l_dv    <= w_l_dv_d;
      if (w_capture) begin
        r_l_rdata[BEAT_W*r_cnt +: BEAT_W] <= m_rdata;
      end
    end
  end

  assign l_dv    = r_l_dv;
  assign l_rdata = r_l_rdata;
  assign m_rd    = r_m_rd;
  assign m_wr    = r_m_wr;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;

endmodule

// File: tb/tb_lbus_resp.sv
// Scoreboard bench for lbus_resp: expected beats and lines are queued at issue time
// and checked as the memory model acknowledges beats and the DUT pulses l_dv.
module tb_lbus_resp;

  typedef struct packed {
    logic        wr;
    logic [63:0] addr;
    logic [63:0] data;
  } beat_t;

  logic          clk;
  logic          clr;
  logic [63:0]   l_addr;
  logic          l_rd;
  logic          l_dv;
  logic [1023:0] l_rdata;
  logic          l_wr;
  logic [1023:0] l_wdata;
  logic          ovf;
  logic [63:0]   m_addr;
  logic          m_rd;
  logic          m_wr;
  logic [63:0]   m_wdata;
  logic [63:0]   m_rdata;
  logic          m_ack;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int waits   = 0;
  int wcnt    = 0;
  int acks    = 0;
  int dv_cnt  = 0;
  int reads_done = 0;
  int issue_cyc  = 0;
  bit dv_seen  = 0;
  bit lat_on   = 0;
  bit first_on = 0;

  beat_t         exp_q[$];
  logic [1023:0] line_q[$];
  logic [63:0]   mem_dut[logic [63:0]];
  logic [63:0]   mem_ref[logic [63:0]];

  lbus_resp dut (
    .clk     (clk),
    .clr     (clr),
    .l_addr  (l_addr),
    .l_rd    (l_rd),
    .l_dv    (l_dv),
    .l_rdata (l_rdata),
    .l_wr    (l_wr),
    .l_wdata (l_wdata),
    .ovf     (ovf),
    .m_addr  (m_addr),
    .m_rd    (m_rd),
    .m_wr    (m_wr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ack   (m_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] dut_get(input logic [63:0] a);
    return mem_dut.exists(a) ? mem_dut[a] : a;
  endfunction

  function automatic logic [63:0] ref_get(input logic [63:0] a);
    return mem_ref.exists(a) ? mem_ref[a] : a;
  endfunction

  function automatic logic [63:0] line_base(input logic [63:0] a);
    return {a[63:7], 7'b0};
  endfunction

  function automatic void push_read(input logic [63:0] a);
    logic [1023:0] ln;
    logic [63:0]   b;
    b = line_base(a);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back('{wr: 1'b0, addr: b + 64'(8 * i), data: 64'd0});
      ln[64*i +: 64] = ref_get(b + 64'(8 * i));
    end
    line_q.push_back(ln);
  endfunction

  function automatic void push_write(input logic [63:0] a, input logic [1023:0] d);
    logic [63:0] b;
    b = line_base(a);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back('{wr: 1'b1, addr: b + 64'(8 * i), data: d[64*i +: 64]});
      mem_ref[b + 64'(8 * i)] = d[64*i +: 64];
    end
  endfunction

  // Memory model, beat scoreboard and line checker, all evaluated on the falling edge.
  initial begin
    beat_t         e;
    logic [1023:0] ln;
    m_ack   = 1'b0;
    m_rdata = 64'd0;
    forever begin
      @(negedge clk);
      if (clr) begin
        m_ack = 1'b0;
        wcnt  = 0;
      end else begin
        check("rd_wr_excl", 64'(m_rd & m_wr), 64'd0);
        if (first_on && m_rd) begin
          check("first_rd_lat", 64'(cyc - issue_cyc), 64'd1);
          first_on = 0;
        end
        if (m_rd || m_wr) begin
          if (exp_q.size() == 0) begin
            check("beat_q_empty", 64'(exp_q.size()), 64'd1);
          end else begin
            e = exp_q[0];
            check("beat_kind", 64'(m_wr), 64'(e.wr));
            check("beat_addr", m_addr, e.addr);
            if (e.wr) check("beat_wdata", m_wdata, e.data);
          end
          if (wcnt >= waits) begin
            m_ack = 1'b1;
            if (m_rd) m_rdata = dut_get(m_addr);
            else      mem_dut[m_addr] = m_wdata;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            wcnt = 0;
            acks++;
          end else begin
            m_ack = 1'b0;
            wcnt++;
          end
        end else begin
          m_ack = 1'b0;
          wcnt  = 0;
        end
        if (l_dv) begin
          dv_cnt++;
          dv_seen = 1;
          if (line_q.size() == 0) begin
            check("dv_q_empty", 64'(line_q.size()), 64'd1);
          end else begin
            ln = line_q.pop_front();
            for (int i = 0; i < 16; i++) check("line_beat", l_rdata[64*i +: 64], ln[64*i +: 64]);
          end
          if (lat_on) begin
            check("rd_latency", 64'(cyc - issue_cyc), 64'd18);
            lat_on = 0;
          end
        end
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic wait_dv();
    for (int i = 0; i < 400 && !dv_seen; i++) @(posedge clk);
    #1;
    check("dv_timeout", 64'(dv_seen), 64'd1);
    l_rd = 1'b0;
    reads_done++;
  endtask

  task automatic do_read(input logic [63:0] a, input bit timed);
    l_addr  = a;
    l_rd    = 1'b1;
    dv_seen = 0;
    push_read(a);
    if (timed) begin
      issue_cyc = cyc;
      lat_on    = 1;
      first_on  = 1;
    end
    wait_dv();
  endtask

  task automatic do_write(input logic [63:0] a, input logic [1023:0] d, input bit accept);
    l_addr  = a;
    l_wdata = d;
    l_wr    = 1'b1;
    if (accept) push_write(a, d);
    @(posedge clk);
    #1;
    l_wr = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && (exp_q.size() != 0 || m_rd || m_wr); i++) @(posedge clk);
    #1;
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [1023:0] d;
    clr     = 1'b1;
    l_addr  = 64'd0;
    l_rd    = 1'b0;
    l_wr    = 1'b0;
    l_wdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_l_dv", 64'(l_dv), 64'd0);
    check("rst_l_rdata", 64'(|l_rdata), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_m_rd", 64'(m_rd), 64'd0);
    check("rst_m_wr", 64'(m_wr), 64'd0);
    check("rst_m_addr", m_addr, 64'd0);
    check("rst_m_wdata", m_wdata, 64'd0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    @(posedge clk);
    #1;

    // Zero-wait read with latency checks.
    waits = 0;
    do_read(64'h1000, 1'b1);

    // Wait-state read: beats held through waits, exactly 16 acks, one l_dv.
    waits = 3;
    acks  = 0;
    do_read(64'h2080, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("ws_acks", 64'(acks), 64'd16);
    check("ws_dv_cnt", 64'(dv_cnt), 64'(reads_done));

    // Write drain.
    waits = 0;
    for (int i = 0; i < 16; i++) d[64*i +: 64] = 64'hA5A5_0000 + 64'(i);
    do_write(64'h3000, d, 1'b1);
    wait_drain();
    check("wr_m_wr_idle", 64'(m_wr), 64'd0);

    // Write and read together: all writes precede reads, read returns written data.
    waits = 1;
    for (int i = 0; i < 16; i++) d[64*i +: 64] = 64'h4444_0000 + 64'(3 * i);
    l_rd    = 1'b1;
    dv_seen = 0;
    push_write(64'h4000, d);
    push_read(64'h4000);
    l_addr  = 64'h4000;
    l_wdata = d;
    l_wr    = 1'b1;
    @(posedge clk);
    #1;
    l_wr = 1'b0;
    wait_dv();

    // Overrun: second write during drain is dropped and ovf sticks.
    waits = 3;
    for (int i = 0; i < 16; i++) d[64*i +: 64] = 64'h5555_0000 + 64'(i);
    do_write(64'h5000, d, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) d[64*i +: 64] = 64'h6666_0000 + 64'(i);
    do_write(64'h6000, d, 1'b0);
    check("ovf_set", 64'(ovf), 64'd1);
    wait_drain();
    repeat (2) @(posedge clk);
    #1;
    check("ovf_sticky", 64'(ovf), 64'd1);
    check("ovf_no_write", 64'(mem_dut.exists(64'h6000)), 64'd0);

    // Reset at beat 7 of a read.
    waits = 0;
    acks  = 0;
    l_addr  = 64'h9000;
    l_rd    = 1'b1;
    dv_seen = 0;
    push_read(64'h9000);
    for (int i = 0; i < 100 && acks < 7; i++) @(posedge clk);
    #1;
    check("clr_reach7", 64'(acks), 64'd7);
    clr  = 1'b1;
    l_rd = 1'b0;
    exp_q.delete();
    line_q.delete();
    @(negedge clk);
    check("clr_m_rd", 64'(m_rd), 64'd0);
    check("clr_l_dv", 64'(l_dv), 64'd0);
    check("clr_m_addr", m_addr, 64'd0);
    check("clr_l_rdata", 64'(|l_rdata), 64'd0);
    check("clr_ovf", 64'(ovf), 64'd0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    @(posedge clk);
    #1;

    do_read(64'h7000, 1'b1);
    // Offset bits inside the line are ignored.
    waits = 1;
    do_read(64'h8047, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("final_dv_cnt", 64'(dv_cnt), 64'(reads_done));
    check("final_q_empty", 64'(exp_q.size() + line_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
